// File: rtl/cpu7_csr_pipe_if.sv
// cpu7_csr_pipe_if: CSR write-pipeline bus between decode/ALU/bypass logic and the CSR pipe.
interface cpu7_csr_pipe_if #(
    parameter int CSR_BIT = 14,
    parameter int DATA_W  = 32
);
    logic               csr_wen_d;
    logic [CSR_BIT-1:0] csr_waddr_d;
    logic [DATA_W-1:0]  csr_wdata_e;
    logic               stall_e;
    logic               stall_m;
    logic               flush_e;
    logic               flush_m;
    logic               csr_mux_sel_csrrf;
    logic               csr_mux_sel_e;
    logic               csr_mux_sel_m;
    logic [DATA_W-1:0]  csr_rf_rdata;
    logic               csr_wen_e;
    logic [CSR_BIT-1:0] csr_waddr_e;
    logic               csr_wen_m;
    logic [CSR_BIT-1:0] csr_waddr_m;
    logic [DATA_W-1:0]  csr_wdata_m;
    logic               csr_rf_wen;
    logic [CSR_BIT-1:0] csr_rf_waddr;
    logic [DATA_W-1:0]  csr_rf_wdata;
    logic [DATA_W-1:0]  csr_rdata_d;
    logic               csr_busy;

    modport master (
        output csr_wen_d, csr_waddr_d, csr_wdata_e, stall_e, stall_m, flush_e, flush_m,
               csr_mux_sel_csrrf, csr_mux_sel_e, csr_mux_sel_m, csr_rf_rdata,
        input  csr_wen_e, csr_waddr_e, csr_wen_m, csr_waddr_m, csr_wdata_m,
               csr_rf_wen, csr_rf_waddr, csr_rf_wdata, csr_rdata_d, csr_busy
    );

    modport slave (
        input  csr_wen_d, csr_waddr_d, csr_wdata_e, stall_e, stall_m, flush_e, flush_m,
               csr_mux_sel_csrrf, csr_mux_sel_e, csr_mux_sel_m, csr_rf_rdata,
        output csr_wen_e, csr_waddr_e, csr_wen_m, csr_waddr_m, csr_wdata_m,
               csr_rf_wen, csr_rf_waddr, csr_rf_wdata, csr_rdata_d, csr_busy
    );
endinterface

// File: rtl/cpu7_csr_pipe.sv
// cpu7_csr_pipe: carries CSR writes D->E->M, commits at end of M, and steers the bypassed D read value.
module cpu7_csr_pipe #(
    parameter int CSR_BIT = 14,
    parameter int DATA_W  = 32
) (
    input logic          clk,
    input logic          reset,
    cpu7_csr_pipe_if.slave bus
);
    logic               wen_e_q, wen_e_d, wen_m_q, wen_m_d;
    logic [CSR_BIT-1:0] waddr_e_q, waddr_e_d, waddr_m_q, waddr_m_d;
    logic [DATA_W-1:0]  wdata_m_q, wdata_m_d;

    always_comb begin
        wen_e_d   = wen_e_q;
        waddr_e_d = waddr_e_q;
        wen_m_d   = wen_m_q;
        waddr_m_d = waddr_m_q;
        wdata_m_d = wdata_m_q;
        if (bus.flush_e || bus.flush_m) begin
            wen_e_d = 1'b0;
        end else if (!bus.stall_e) begin
            wen_e_d   = bus.csr_wen_d;
            waddr_e_d = bus.csr_waddr_d;
        end
        // A stalled E with a free M leaves a bubble behind rather than duplicating the E write
        if (bus.flush_m) begin
            wen_m_d = 1'b0;
        end else if (!bus.stall_m) begin
            wen_m_d = bus.stall_e ? 1'b0 : wen_e_q;
            if (!bus.stall_e) begin
                waddr_m_d = waddr_e_q;
                wdata_m_d = bus.csr_wdata_e;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wen_e_q   <= 1'b0;
            waddr_e_q <= '0;
            wen_m_q   <= 1'b0;
            waddr_m_q <= '0;
            wdata_m_q <= '0;
        end else begin
            wen_e_q   <= wen_e_d;
            waddr_e_q <= waddr_e_d;
            wen_m_q   <= wen_m_d;
            waddr_m_q <= waddr_m_d;
            wdata_m_q <= wdata_m_d;
        end
    end

    assign bus.csr_wen_e    = wen_e_q;
    assign bus.csr_waddr_e  = waddr_e_q;
    assign bus.csr_wen_m    = wen_m_q;
    assign bus.csr_waddr_m  = waddr_m_q;
    assign bus.csr_wdata_m  = wdata_m_q;
    assign bus.csr_rf_wen   = wen_m_q && !bus.stall_m && !bus.flush_m;
    assign bus.csr_rf_waddr = waddr_m_q;
    assign bus.csr_rf_wdata = wdata_m_q;
    assign bus.csr_busy     = wen_e_q || wen_m_q;
    assign bus.csr_rdata_d  = bus.csr_mux_sel_e ? bus.csr_wdata_e :
                              bus.csr_mux_sel_m ? wdata_m_q : bus.csr_rf_rdata;

    a_stall_order: assert property (@(posedge clk) disable iff (reset) bus.stall_m |-> bus.stall_e);
endmodule

// File: tb/tb_cpu7_csr_pipe.sv
// tb_cpu7_csr_pipe: directed scenarios plus randomized traffic checked against an in-flight write model.
module tb_cpu7_csr_pipe;
    localparam int CB = 14;
    localparam int DW = 32;

    typedef struct {
        bit            live;
        logic [CB-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    int   dut_commits = 0;
    int   ref_commits = 0;
    wr_t  in_e, in_m;
    logic [DW-1:0] last_commit_data;

    cpu7_csr_pipe_if #(.CSR_BIT(CB), .DATA_W(DW)) bus ();
    cpu7_csr_pipe #(.CSR_BIT(CB), .DATA_W(DW)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        in_e = '{live: 1'b0, addr: '0, data: '0};
        in_m = '{live: 1'b0, addr: '0, data: '0};
    endtask

    // Writes are tracked as records moving through two slots; a record commits as it leaves M.
    task automatic model_step();
        wr_t old_e;
        if (reset) begin
            model_clear();
            return;
        end
        old_e = in_e;
        if (in_m.live && !bus.stall_m && !bus.flush_m) begin
            ref_commits++;
            last_commit_data = in_m.data;
        end
        if (bus.flush_m) begin
            in_e.live = 1'b0;
            in_m.live = 1'b0;
            return;
        end
        if (!bus.stall_m)
            in_m = bus.stall_e ? '{live: 1'b0, addr: in_m.addr, data: in_m.data}
                               : '{live: old_e.live, addr: old_e.addr, data: bus.csr_wdata_e};
        if (bus.flush_e)
            in_e.live = 1'b0;
        else if (!bus.stall_e)
            in_e = '{live: bus.csr_wen_d, addr: bus.csr_waddr_d, data: '0};
    endtask

    task automatic check_outputs();
        bit            commit_exp;
        logic [DW-1:0] rd_exp;
        commit_exp = in_m.live && !bus.stall_m && !bus.flush_m;
        if (bus.csr_mux_sel_e)      rd_exp = bus.csr_wdata_e;
        else if (bus.csr_mux_sel_m) rd_exp = in_m.data;
        else                        rd_exp = bus.csr_rf_rdata;
        chk("wen_e", bus.csr_wen_e, in_e.live);
        chk("waddr_e", bus.csr_waddr_e, in_e.addr);
        chk("wen_m", bus.csr_wen_m, in_m.live);
        chk("waddr_m", bus.csr_waddr_m, in_m.addr);
        chk("wdata_m", bus.csr_wdata_m, in_m.data);
        chk("rf_wen", bus.csr_rf_wen, commit_exp);
        if (commit_exp) begin
            chk("rf_waddr", bus.csr_rf_waddr, in_m.addr);
            chk("rf_wdata", bus.csr_rf_wdata, in_m.data);
        end
        chk("busy", bus.csr_busy, in_e.live || in_m.live);
        chk("rdata_d", bus.csr_rdata_d, rd_exp);
        if (bus.csr_rf_wen === 1'b1) dut_commits++;
    endtask

    task automatic tick();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        bus.csr_wen_d = 1'b0;
        bus.csr_waddr_d = '0;
        bus.csr_wdata_e = '0;
        bus.stall_e = 1'b0;
        bus.stall_m = 1'b0;
        bus.flush_e = 1'b0;
        bus.flush_m = 1'b0;
        bus.csr_mux_sel_csrrf = 1'b1;
        bus.csr_mux_sel_e = 1'b0;
        bus.csr_mux_sel_m = 1'b0;
    endtask

    initial begin
        int c0;
        int r;
        idle();
        bus.csr_rf_rdata = 32'h1357;
        model_clear();
        last_commit_data = '0;
        tick();
        tick();
        chk("rst_wen_e", bus.csr_wen_e, 1'b0);
        chk("rst_wen_m", bus.csr_wen_m, 1'b0);
        chk("rst_rf_wen", bus.csr_rf_wen, 1'b0);
        chk("rst_busy", bus.csr_busy, 1'b0);
        chk("rst_rdata", bus.csr_rdata_d, 32'h1357);
        reset = 1'b0;
        tick();

        // reset arriving while a write sits in E
        c0 = dut_commits;
        bus.csr_wen_d = 1'b1;
        bus.csr_waddr_d = 14'h005;
        tick();
        bus.csr_wen_d = 1'b0;
        reset = 1'b1;
        model_clear();
        #1;
        chk("rstmid_wen_e", bus.csr_wen_e, 1'b0);
        chk("rstmid_wen_m", bus.csr_wen_m, 1'b0);
        tick();
        reset = 1'b0;
        repeat (4) tick();
        chk("rstmid_no_commit", dut_commits - c0, 0);

        // single write, no stalls: strobe exactly two cycles after issue
        bus.csr_wen_d = 1'b1;
        bus.csr_waddr_d = 14'h006;
        tick();
        bus.csr_wen_d = 1'b0;
        bus.csr_wdata_e = 32'hDEAD_BEEF;
        chk("single_e", bus.csr_wen_e, 1'b1);
        chk("single_early", bus.csr_rf_wen, 1'b0);
        tick();
        bus.csr_wdata_e = '0;
        chk("single_wen", bus.csr_rf_wen, 1'b1);
        chk("single_addr", bus.csr_rf_waddr, 14'h006);
        chk("single_data", bus.csr_rf_wdata, 32'hDEAD_BEEF);
        tick();
        chk("single_once", bus.csr_rf_wen, 1'b0);

        // bypass selects
        bus.csr_mux_sel_csrrf = 1'b0;
        bus.csr_mux_sel_e = 1'b1;
        bus.csr_wdata_e = 32'h1234;
        #1 chk("byp_e", bus.csr_rdata_d, 32'h1234);
        bus.csr_mux_sel_e = 1'b0;
        bus.csr_mux_sel_csrrf = 1'b1;
        bus.csr_wen_d = 1'b1;
        bus.csr_waddr_d = 14'h007;
        tick();
        bus.csr_wen_d = 1'b0;
        bus.csr_wdata_e = 32'hAA55;
        tick();
        bus.csr_wdata_e = '0;
        bus.csr_mux_sel_csrrf = 1'b0;
        bus.csr_mux_sel_m = 1'b1;
        #1 chk("byp_m", bus.csr_rdata_d, 32'hAA55);
        bus.csr_mux_sel_m = 1'b0;
        bus.csr_mux_sel_csrrf = 1'b1;
        bus.csr_rf_rdata = 32'h0F0F;
        #1 chk("byp_rf", bus.csr_rdata_d, 32'h0F0F);
        tick();

        // M held for three cycles commits exactly once, on release
        bus.csr_wen_d = 1'b1;
        bus.csr_waddr_d = 14'h008;
        tick();
        bus.csr_wen_d = 1'b0;
        bus.csr_wdata_e = 32'h11;
        tick();
        bus.stall_e = 1'b1;
        bus.stall_m = 1'b1;
        c0 = dut_commits;
        for (int i = 0; i < 3; i++) begin
            #1 chk("stall_hold", bus.csr_rf_wen, 1'b0);
            tick();
        end
        bus.stall_e = 1'b0;
        bus.stall_m = 1'b0;
        #1 chk("stall_release", bus.csr_rf_wen, 1'b1);
        chk("stall_data", bus.csr_rf_wdata, 32'h11);
        tick();
        chk("stall_one_pulse", dut_commits - c0, 1);

        // flush_m kills both E and M
        bus.csr_wen_d = 1'b1;
        bus.csr_waddr_d = 14'h009;
        tick();
        bus.csr_waddr_d = 14'h00A;
        bus.csr_wdata_e = 32'h1;
        tick();
        bus.csr_wen_d = 1'b0;
        c0 = dut_commits;
        chk("flush_pre_busy", bus.csr_busy, 1'b1);
        bus.flush_m = 1'b1;
        tick();
        bus.flush_m = 1'b0;
        chk("flush_wen_e", bus.csr_wen_e, 1'b0);
        chk("flush_wen_m", bus.csr_wen_m, 1'b0);
        chk("flush_busy", bus.csr_busy, 1'b0);
        tick();
        chk("flush_no_commit", dut_commits - c0, 0);

        // back-to-back writes to the same CSR
        bus.csr_wen_d = 1'b1;
        bus.csr_waddr_d = 14'h000;
        tick();
        bus.csr_wdata_e = 32'h1;
        tick();
        bus.csr_wen_d = 1'b0;
        bus.csr_wdata_e = 32'h2;
        chk("b2b_first", bus.csr_rf_wen, 1'b1);
        chk("b2b_first_data", bus.csr_rf_wdata, 32'h1);
        tick();
        chk("b2b_second", bus.csr_rf_wen, 1'b1);
        chk("b2b_second_data", bus.csr_rf_wdata, 32'h2);
        tick();
        chk("b2b_last", last_commit_data, 32'h2);
        chk("b2b_done", bus.csr_rf_wen, 1'b0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bus.csr_wen_d = 1'($urandom_range(0, 1));
            bus.csr_waddr_d = 14'($urandom_range(0, 15));
            bus.csr_wdata_e = $urandom;
            bus.stall_e = ($urandom_range(0, 3) == 0);
            bus.stall_m = bus.stall_e && ($urandom_range(0, 1) == 1);
            bus.flush_e = ($urandom_range(0, 9) == 0);
            bus.flush_m = ($urandom_range(0, 15) == 0);
            bus.csr_rf_rdata = $urandom;
            r = $urandom_range(0, 7);
            bus.csr_mux_sel_e = (r == 0) || (r >= 3 && r[0]);
            bus.csr_mux_sel_m = (r == 1) || (r >= 3 && r[1]);
            bus.csr_mux_sel_csrrf = (r == 2) || (r >= 3 && r[2]);
            tick();
        end
        idle();
        repeat (3) tick();
        chk("commit_total", dut_commits, ref_commits);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
